// File: rtl/l2_mem_ctrl.sv
// Single-beat 64-bit memory sequencer between the L2 cache and a DRAM-style command interface.
// Define MEM_OPEN_PAGE_EN to keep the row open between accesses (open-page policy).
module l2_mem_ctrl #(
  parameter int ROW_W       = 14,
  parameter int COL_W       = 10,
  parameter int T_RCD       = 2,
  parameter int T_RP        = 2,
  parameter int STB_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [63:0]      req_wdata,
  output logic             rsp_valid,
  output logic [63:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [ROW_W-1:0] mem_addr,
  output logic             mem_cs_n,
  output logic             mem_ras_n,
  output logic             mem_cas_n,
  output logic             mem_we_n,
  output logic [63:0]      mem_data_out,
  output logic             mem_data_oe,
  input  logic [63:0]      mem_data_in,
  input  logic             mem_stb
);
  localparam int WMAX   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int WAIT_W = $clog2(WMAX + 1);
  localparam int TO_W   = $clog2(STB_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ACTIVATE, RCD_WAIT, ACCESS, DATA_WAIT, PRECHARGE, RP_WAIT, RESP
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  row_q, row_in;
  logic [COL_W-1:0]  col_q, col_in;
  logic              we_q, err_q;
  logic [63:0]       wdata_q, rdata_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
`ifdef MEM_OPEN_PAGE_EN
  logic [ROW_W-1:0]  open_row;
  logic              open_valid, pre_then_act;
`endif

  assign col_in = req_addr[COL_W+2:3];
  assign row_in = req_addr[ROW_W+COL_W+2:COL_W+3];

  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ROW_W+COL_W+3], req_addr[2:0]};

  // Pins are assigned on the transition into a state, so they show the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      mem_cs_n     <= 1'b1;
      mem_ras_n    <= 1'b1;
      mem_cas_n    <= 1'b1;
      mem_we_n     <= 1'b1;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_data_oe  <= 1'b0;
      wait_cnt     <= '0;
      to_cnt       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifdef MEM_OPEN_PAGE_EN
      open_row     <= '0;
      open_valid   <= 1'b0;
      pre_then_act <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_cs_n  <= 1'b0;
      mem_ras_n <= 1'b1;
      mem_cas_n <= 1'b1;
      mem_we_n  <= 1'b1;
      case (state)
        IDLE: begin
          mem_cs_n <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            row_q     <= row_in;
            col_q     <= col_in;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            mem_cs_n  <= 1'b0;
`ifdef MEM_OPEN_PAGE_EN
            if (open_valid && open_row == row_in) begin
              state        <= ACCESS;
              mem_cas_n    <= 1'b0;
              mem_we_n     <= ~req_we;
              mem_addr     <= ROW_W'(col_in);
              mem_data_oe  <= req_we;
              mem_data_out <= req_wdata;
            end else if (open_valid) begin
              state        <= PRECHARGE;
              mem_ras_n    <= 1'b0;
              mem_we_n     <= 1'b0;
              pre_then_act <= 1'b1;
            end else
`endif
            begin
              state     <= ACTIVATE;
              mem_ras_n <= 1'b0;
              mem_addr  <= row_in;
            end
          end
        end
        ACTIVATE, RCD_WAIT: begin
          if (state == ACTIVATE && T_RCD > 1) begin
            state    <= RCD_WAIT;
            wait_cnt <= WAIT_W'(T_RCD - 1);
          end else if (state == RCD_WAIT && wait_cnt != WAIT_W'(1)) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            state        <= ACCESS;
            mem_cas_n    <= 1'b0;
            mem_we_n     <= ~we_q;
            mem_addr     <= ROW_W'(col_q);
            mem_data_oe  <= we_q;
            mem_data_out <= wdata_q;
          end
        end
        ACCESS: begin
          state  <= DATA_WAIT;
          to_cnt <= '0;
        end
        DATA_WAIT: begin
          // The strobe is checked first so a completion on the last allowed cycle is not an error.
          if (!mem_stb) begin
            mem_data_oe <= 1'b0;
`ifdef MEM_OPEN_PAGE_EN
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_rdata  <= we_q ? '0 : mem_data_in;
            open_row   <= row_q;
            open_valid <= 1'b1;
`else
            state     <= PRECHARGE;
            mem_ras_n <= 1'b0;
            mem_we_n  <= 1'b0;
            rdata_q   <= we_q ? '0 : mem_data_in;
            err_q     <= 1'b0;
`endif
          end else if (to_cnt == TO_W'(STB_TIMEOUT - 1)) begin
            mem_data_oe <= 1'b0;
            state       <= PRECHARGE;
            mem_ras_n   <= 1'b0;
            mem_we_n    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b1;
`ifdef MEM_OPEN_PAGE_EN
            pre_then_act <= 1'b0;
            open_valid   <= 1'b0;
`endif
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        PRECHARGE, RP_WAIT: begin
          if (state == PRECHARGE && T_RP > 1) begin
            state    <= RP_WAIT;
            wait_cnt <= WAIT_W'(T_RP - 1);
          end else if (state == RP_WAIT && wait_cnt != WAIT_W'(1)) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else
`ifdef MEM_OPEN_PAGE_EN
          if (pre_then_act) begin
            pre_then_act <= 1'b0;
            state        <= ACTIVATE;
            mem_ras_n    <= 1'b0;
            mem_addr     <= row_q;
          end else
`endif
          begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_q;
            rsp_err   <= err_q;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_cs_n  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Self-checking bench for l2_mem_ctrl: per-cycle pin timeline predicted from the access rules.
module tb_l2_mem_ctrl;
  localparam int ROW_W = 14, COL_W = 10, T_RCD = 2, T_RP = 2, STB_TIMEOUT = 16;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             req_valid = 1'b0, req_we = 1'b0, req_ready;
  logic [31:0]      req_addr = '0;
  logic [63:0]      req_wdata = '0, mem_data_in = '0;
  logic             rsp_valid, rsp_err, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;
  logic             mem_data_oe, mem_stb = 1'b1;
  logic [63:0]      rsp_rdata, mem_data_out;
  logic [ROW_W-1:0] mem_addr;
  int               n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  l2_mem_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP),
                .STB_TIMEOUT(STB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_cs_n(mem_cs_n), .mem_ras_n(mem_ras_n),
    .mem_cas_n(mem_cas_n), .mem_we_n(mem_we_n), .mem_data_out(mem_data_out),
    .mem_data_oe(mem_data_oe), .mem_data_in(mem_data_in), .mem_stb(mem_stb));

  function automatic logic [ROW_W-1:0] row_of(input logic [31:0] a);
    return ROW_W'((a >> (COL_W + 3)) % (32'd1 << ROW_W));
  endfunction
  function automatic logic [ROW_W-1:0] col_of(input logic [31:0] a);
    return ROW_W'((a >> 3) % (32'd1 << COL_W));
  endfunction

  // Starts after a negedge with the controller idle; ends after the negedge of the ready cycle.
  // k < 0 means the strobe never comes and the access must time out.
  task automatic run_txn(input string nm, input logic we, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd, input int k,
                         input bit glitch);
    int a = 1, acc = 1 + T_RCD, dw0 = 2 + T_RCD;
    int d = (k >= 0) ? dw0 + k : dw0 + STB_TIMEOUT - 1;
    int pre = d + 1, rsp = pre + T_RP, rdy = rsp + 1;
    logic exp_err = (k < 0);
    logic [63:0] exp_rd = (exp_err || we) ? 64'd0 : rd;
    logic [3:0] exp_cmd;
    logic exp_oe;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= rdy; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom_range(0, 1));
      req_addr = $urandom; req_wdata = {$urandom, $urandom};
      if (c >= dw0 && c <= d) mem_stb = !(k >= 0 && c == d);
      else if (glitch && c == acc) mem_stb = 1'b0;
      else mem_stb = 1'($urandom_range(0, 1));
      mem_data_in = (c == d) ? rd : {$urandom, $urandom};
      @(negedge clk);
      if (c == a) exp_cmd = 4'b0011;
      else if (c == acc) exp_cmd = {3'b010, ~we};
      else if (c == pre) exp_cmd = 4'b0010;
      else exp_cmd = 4'b0111;
      if (c == rdy) begin
        n_tests++;
        if (mem_cs_n !== 1'b1) begin
          n_fail++; $display("FAIL %s deselect cyc %0d: got %b want 1", nm, c, mem_cs_n);
        end
      end else if (c != rsp) begin
        n_tests++;
        if ({mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n} !== exp_cmd) begin
          n_fail++;
          $display("FAIL %s cmd cyc %0d: got %b want %b", nm, c,
                   {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n}, exp_cmd);
        end
      end
      if (c == a || c == acc) begin
        n_tests++;
        if (mem_addr !== ((c == a) ? row_of(addr) : col_of(addr))) begin
          n_fail++;
          $display("FAIL %s addr cyc %0d: got %h want %h", nm, c, mem_addr,
                   (c == a) ? row_of(addr) : col_of(addr));
        end
      end
      exp_oe = we && c >= acc && c <= d;
      n_tests++;
      if ({mem_data_oe, rsp_valid, req_ready} !== {exp_oe, c == rsp, c == rdy}) begin
        n_fail++;
        $display("FAIL %s oe/rsp/ready cyc %0d: got %b want %b", nm, c,
                 {mem_data_oe, rsp_valid, req_ready}, {exp_oe, c == rsp, c == rdy});
      end
      if (exp_oe) begin
        n_tests++;
        if (mem_data_out !== wd) begin
          n_fail++; $display("FAIL %s wdata cyc %0d: got %h want %h", nm, c, mem_data_out, wd);
        end
      end
      if (c == rsp) begin
        n_tests++;
        if ({rsp_err, rsp_rdata} !== {exp_err, exp_rd}) begin
          n_fail++;
          $display("FAIL %s rsp: got err %b data %h want err %b data %h", nm,
                   rsp_err, rsp_rdata, exp_err, exp_rd);
        end
      end
    end
    mem_stb = 1'b1;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; mem_stb = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if ({req_ready, rsp_valid, mem_cs_n} !== 3'b101) begin
        n_fail++;
        $display("FAIL idle ready/rsp/cs: got %b want 101", {req_ready, rsp_valid, mem_cs_n});
      end
    end
    mem_stb = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({req_ready, rsp_valid, rsp_err, mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n,
           mem_data_oe} !== 8'b1001_1110) begin
        n_fail++;
        $display("FAIL reset ctrl: got %b want 10011110", {req_ready, rsp_valid, rsp_err,
                 mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n, mem_data_oe});
      end
      n_tests++;
      if ({rsp_rdata, mem_data_out, mem_addr} !== '0) begin
        n_fail++;
        $display("FAIL reset data: got %h %h %h want 0", rsp_rdata, mem_data_out, mem_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset_mid_access;
    int dw0 = 2 + T_RCD;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 64'hA5A5_0000_FFFF_1234;
    for (int c = 1; c <= dw0 + 1; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_stb = 1'b1;
      if (c == dw0 + 1) rst_n = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if (mem_data_oe !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid oe_before: got %b want 1", mem_data_oe);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n, mem_data_oe, req_ready, rsp_valid}
        !== 7'b1111_010) begin
      n_fail++;
      $display("FAIL rst_mid pins: got %b want 1111010", {mem_cs_n, mem_ras_n, mem_cas_n,
               mem_we_n, mem_data_oe, req_ready, rsp_valid});
    end
    idle_gap(12);
  endtask

`ifdef MEM_OPEN_PAGE_EN
  // Records the first cycle of each command; the strobe is returned the cycle after CAS.
  task automatic open_txn(input string nm, input logic [31:0] addr, input logic [63:0] rd,
                          input int e_pre, input int e_act, input int e_acc, input int e_rsp);
    int g_pre = -1, g_act = -1, g_acc = -1, g_rsp = -1;
    bit stb_next = 1'b0;
    logic [63:0] got_rd = '0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    for (int c = 1; c <= 30 && g_rsp < 0; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; mem_stb = !stb_next; stb_next = 1'b0; mem_data_in = rd;
      @(negedge clk);
      case ({mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n})
        4'b0010: if (g_pre < 0) g_pre = c;
        4'b0011: if (g_act < 0) g_act = c;
        4'b0101: if (g_acc < 0) begin g_acc = c; stb_next = 1'b1; end
        default: ;
      endcase
      if (rsp_valid) begin g_rsp = c; got_rd = rsp_rdata; end
    end
    mem_stb = 1'b1;
    n_tests++;
    if (g_pre != e_pre || g_act != e_act || g_acc != e_acc || g_rsp != e_rsp) begin
      n_fail++;
      $display("FAIL %s pre/act/acc/rsp cyc: got %0d %0d %0d %0d want %0d %0d %0d %0d", nm,
               g_pre, g_act, g_acc, g_rsp, e_pre, e_act, e_acc, e_rsp);
    end
    n_tests++;
    if (got_rd !== rd) begin
      n_fail++; $display("FAIL %s rdata: got %h want %h", nm, got_rd, rd);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_after: got %b want 1", nm, req_ready);
    end
  endtask

  task automatic test_open_page;
    open_txn("open_first", 32'h0000_0100, 64'h1111_2222_3333_4444, -1, 1, 3, 5);
    open_txn("open_hit",   32'h0000_0108, 64'h5555_6666_7777_8888, -1, -1, 1, 3);
    open_txn("open_miss",  32'h0100_0000, 64'h9999_AAAA_BBBB_CCCC, 1, 3, 5, 7);
  endtask
`else
  task automatic test_read_basic;
    run_txn("read", 1'b0, 32'h0001_2348, 64'd0, 64'hDEAD_BEEF_0000_0001, 0, 1'b0);
  endtask

  task automatic test_write;
    run_txn("write", 1'b1, 32'h0000_0040, 64'h1234_5678_9ABC_DEF0, {$urandom, $urandom}, 2, 1'b0);
  endtask

  task automatic test_timeout;
    run_txn("timeout_rd", 1'b0, $urandom, 64'd0, {$urandom, $urandom}, -1, 1'b0);
    run_txn("timeout_wr", 1'b1, $urandom, {$urandom, $urandom}, 64'd0, -1, 1'b0);
    run_txn("stb_last", 1'b0, $urandom, 64'd0, 64'h0F0F_F0F0_1234_5678, STB_TIMEOUT - 1, 1'b0);
  endtask

  task automatic test_access_glitch;
    run_txn("acc_glitch", 1'b0, 32'h00AB_CDE8, 64'd0, 64'hCAFE_F00D_0000_0003, 3, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_txn("b2b", 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, 4), 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      int k = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      run_txn("rand", 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom},
              {$urandom, $urandom}, k, $urandom_range(0, 3) == 0);
      idle_gap($urandom_range(0, 3));
    end
  endtask
`endif

  initial begin
    test_reset;
    test_reset_mid_access;
`ifdef MEM_OPEN_PAGE_EN
    test_open_page;
`else
    test_read_basic;
    test_write;
    test_timeout;
    test_access_glitch;
    test_back_to_back;
    test_random;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
